itch_length_framer: RTL

- Upstream framing stage. Sits between the transport payload extractor and the bank of speculative ITCH message decoders.
- Input is a MoldUDP64/SoupBinTCP-style message block: a 2-byte big-endian length prefix, then that many ITCH message bytes.
- The block strips the prefix and forwards message bytes on the shared byte_in/valid_in bus that all decoders observe.
- It inserts a guaranteed valid-low gap between messages, so decoders re-arm and detect truncation. It also flags illegal lengths.

---
 rtl/itch_length_framer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/itch_length_framer.sv
// Length-prefix framer: strips the 2-byte big-endian length, forwards message bytes
// on the shared decoder bus, enforces an idle gap between messages and drops illegal lengths.
module itch_length_framer #(
  parameter int unsigned MAX_MSG_LEN = 64,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       byte_out,
  output logic             valid_out,
  output logic             msg_start,
  output logic             msg_end,
  output logic [15:0]      cur_len,
  output logic             err_zero_len,
  output logic             err_oversize,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    DROP,
    GAP
  } state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_MSG_LEN);
  localparam logic [2:0]  GAP_LAST  = 3'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [7:0]       r_len_hi;
  logic [15:0]      r_remaining;
  logic [15:0]      r_cur_len;
  logic [2:0]       r_gap_cnt;
  logic             r_s_ready;
  logic [7:0]       r_byte_out;
  logic             r_valid_out;
  logic             r_msg_start;
  logic             r_msg_end;
  logic             r_err_zero;
  logic             r_err_over;
  logic [CNT_W-1:0] r_msg_count;
  logic [CNT_W-1:0] r_drop_count;

  logic             w_xfer;
  logic [15:0]      w_len;

  assign w_xfer = s_valid && r_s_ready;
  assign w_len  = {r_len_hi, s_byte};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LEN_HI;
      r_len_hi     <= '0;
      r_remaining  <= '0;
      r_cur_len    <= '0;
      r_gap_cnt    <= '0;
      r_s_ready    <= 1'b1;
      r_byte_out   <= '0;
      r_valid_out  <= 1'b0;
      r_msg_start  <= 1'b0;
      r_msg_end    <= 1'b0;
      r_err_zero   <= 1'b0;
      r_err_over   <= 1'b0;
      r_msg_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_valid_out <= 1'b0;
      r_msg_start <= 1'b0;
      r_msg_end   <= 1'b0;
      r_err_zero  <= 1'b0;
      r_err_over  <= 1'b0;
      case (r_state)
        LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= s_byte;
            r_state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            if (w_len == 16'd0) begin
              r_err_zero   <= 1'b1;
              r_drop_count <= sat_inc(r_drop_count);
              r_gap_cnt    <= '0;
              r_s_ready    <= 1'b0;
              r_state      <= GAP;
            end else if (w_len > MAX_LEN16) begin
              r_err_over   <= 1'b1;
              r_drop_count <= sat_inc(r_drop_count);
              r_remaining  <= w_len;
              r_state      <= DROP;
            end else begin
              r_remaining <= w_len;
              r_cur_len   <= w_len;
              r_state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_byte_out  <= s_byte;
            r_valid_out <= 1'b1;
            // remaining still equals the full length only before the first byte
            r_msg_start <= (r_remaining == r_cur_len);
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_msg_end   <= 1'b1;
              r_msg_count <= sat_inc(r_msg_count);
              r_gap_cnt   <= '0;
              r_s_ready   <= 1'b0;
              r_state     <= GAP;
            end
          end
        end
        DROP: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_gap_cnt <= '0;
              r_s_ready <= 1'b0;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_s_ready <= 1'b1;
            r_state   <= LEN_HI;
          end else begin
            r_gap_cnt <= r_gap_cnt + 3'd1;
          end
        end
        default: begin
          r_s_ready <= 1'b1;
          r_state   <= LEN_HI;
        end
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign byte_out     = r_byte_out;
  assign valid_out    = r_valid_out;
  assign msg_start    = r_msg_start;
  assign msg_end      = r_msg_end;
  assign cur_len      = r_cur_len;
  assign err_zero_len = r_err_zero;
  assign err_oversize = r_err_over;
  assign msg_count    = r_msg_count;
  assign drop_count   = r_drop_count;

endmodule
